rtype_issue_ctrl: RTL and testbench
===================================

// Module: rtype_issue_ctrl
//
// PURPOSE
//   In-order issue controller for the single-cycle R-type ALU/register-file datapath.
//   - Accepts 32-bit instructions over a valid/ready handshake and screens out non-R-type encodings.
//   - Buffers legal instructions in a small FIFO.
//   - Issues one instruction per cycle to the datapath's instruction input.
//   - Stalls on read-after-write hazards while a producer's write-back is still in flight.
//
// PARAMETERS
//   DEPTH   4  instruction FIFO entries (power of 2, >=2)
//   WB_LAT  2  cycles from issue until the rd write is visible to a read (>=1)
//
// PORTS
//   clk          in   1                  clock, rising edge
//   rst          in   1                  reset, asynchronous, active-low
//   in_valid     in   1                  upstream instruction valid
//   in_ready     out  1                  FIFO can accept; equals !full
//   in_instr     in   32                 instruction word
//   hold         in   1                  1 = freeze issue (FIFO still accepts)
//   issue_valid  out  1                  issue_instr is valid this cycle
//   issue_instr  out  32                 instruction to datapath; 0 when not valid
//   illegal      out  1                  one-cycle pulse: accepted word was not legal R-type, dropped
//   busy         out  1                  FIFO non-empty OR any scoreboard entry valid
//   fifo_count   out  $clog2(DEPTH)+1    occupancy
//
// BEHAVIOUR
//   - Reset (rst=0, async): FIFO flushed, scoreboard cleared. Outputs go to:
//     issue_valid=0, issue_instr=0, illegal=0, fifo_count=0, busy=0, in_ready=1.
//     Reset mid-operation discards everything, including queued and in-flight instructions.
//   - Accept: occurs when in_valid && in_ready at a clock edge.
//   - Legal encoding: opcode=7'b0110011 AND one of:
//     - funct7=0000000 (any funct3);
//     - funct7=0100000 with funct3=000 (sub) or 101 (sra).
//   - Legal words are pushed. Illegal words are consumed but not pushed, and illegal=1 for the next cycle.
//   - Issue decision (combinational, taken at each edge): head exists && !hold && !hazard.
//     - When taken: pop, issue_valid<=1, issue_instr<=head, and the scoreboard is pushed.
//     - Otherwise: issue_valid<=0, issue_instr<=0.
//   - Latency: a word accepted at edge N issues at earliest at edge N+1. Sustained throughput is 1 per cycle.
//   - Scoreboard: shift register sb[0..WB_LAT-1] of {v, rd[4:0]}.
//     - Every edge: sb[i]<=sb[i-1].
//     - sb[0]<={issued && rd!=0, rd}.
//   - Hazard: any sb[k].v with sb[k].rd == head.rs1 or head.rs2. Reads of x0 never hazard.
//   - A dependent instruction therefore issues WB_LAT+1 cycles after its producer (WB_LAT bubbles).
//   - Simultaneous push and pop: count is unchanged. When full, in_ready=0; there is no pass-through.
//   - Pointers wrap modulo DEPTH. fifo_count ranges 0..DEPTH.
//   - An illegal accept while full cannot occur, because in_ready gates all accepts.
//
// CONFIGURATION
//   PERF_CNT_EN defined:
//   - Adds ports perf_issued (out, 32) and perf_stall (out, 32).
//   - perf_issued increments on every issue.
//   - perf_stall increments on every cycle in which the head exists && !hold && hazard.
//   - Both counters reset to 0 and wrap at 2^32.
//   PERF_CNT_EN undefined:
//   - Neither port nor counter exists. All other behaviour is identical.
//
// STRUCTURE
//   Package rtype_pkg holds:
//   - OPC_RTYPE, F7_BASE, F7_ALT, F3_ADD, F3_SR constants;
//   - sb_entry_t {v, rd} typedef;
//   - field-extract functions rs1/rs2/rd/funct3/funct7.
//   Sub-module rtype_instr_fifo (DEPTH x 32, push/pop/full/empty/count). Decode, scoreboard and issue logic stay in the top.
//
// TESTING
//   1. Reset: assert rst=0 mid-stream, with 2 queued and 1 in flight.
//      -> Immediately: issue_valid=0, fifo_count=0, busy=0, in_ready=1.
//      -> After release, no stale issue.
//   2. Independent pair: accept 0000000_00100_00111_000_01001_0110011 (add x9,x7,x4), then 0000000_01010_00101_000_01101_0110011 (add x13,x5,x10) on consecutive edges.
//      -> Both issue on consecutive cycles, first one cycle after its accept.
//   3. RAW: add x13,x5,x10 then 0100000_01101_00101_000_10011_0110011 (sub x19,x5,x13), with WB_LAT=2.
//      -> sub issues 3 cycles after add, with 2 bubble cycles.
//      -> perf_stall += 2 when PERF_CNT_EN is defined.
//   4. x0: add x0,x7,x4 then add x9,x0,x0.
//      -> Second issues the next cycle; no stall.
//   5. Illegal: accept 32'h1234_5678 and 0100000_00100_00111_111_01001_0110011 (funct7 alt + and).
//      -> illegal pulses once per word; fifo_count unchanged; no issue.
//   6. Full: hold=1, offer 5 independent instructions.
//      -> in_ready drops after 4 and fifo_count=4.
//      -> Release hold: 4 issue back-to-back, then the 5th is accepted and issued.

Source files
------------

// File: rtl/rtype_issue_ctrl_pkg.sv
// rtl/rtype_issue_ctrl_pkg.sv - R-type encoding constants, scoreboard entry type and field helpers
package rtype_pkg;

    localparam logic [6:0] OPC_RTYPE = 7'b0110011;
    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [2:0] F3_ADD    = 3'b000;
    localparam logic [2:0] F3_SR     = 3'b101;

    typedef struct packed {
        logic       v;
        logic [4:0] rd;
    } sb_entry_t;

    function automatic logic [4:0] rs1(input logic [31:0] instr);
        return instr[19:15];
    endfunction

    function automatic logic [4:0] rs2(input logic [31:0] instr);
        return instr[24:20];
    endfunction

    function automatic logic [4:0] rd(input logic [31:0] instr);
        return instr[11:7];
    endfunction

    function automatic logic [2:0] funct3(input logic [31:0] instr);
        return instr[14:12];
    endfunction

    function automatic logic [6:0] funct7(input logic [31:0] instr);
        return instr[31:25];
    endfunction

    // The alternate funct7 only encodes sub and sra.
    function automatic logic is_legal(input logic [31:0] instr);
        logic w_alt_ok;
        w_alt_ok = (funct7(instr) == F7_ALT) &&
                   ((funct3(instr) == F3_ADD) || (funct3(instr) == F3_SR));
        return (instr[6:0] == OPC_RTYPE) && ((funct7(instr) == F7_BASE) || w_alt_ok);
    endfunction

endpackage

// File: rtl/rtype_issue_ctrl_if.sv
// rtl/rtype_issue_ctrl_if.sv - instruction intake and issue bus of the R-type issue controller
interface rtype_issue_ctrl_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_instr;
    logic          hold;
    logic          issue_valid;
    logic [31:0]   issue_instr;
    logic          illegal;
    logic          busy;
    logic [CW-1:0] fifo_count;

    modport master (
        output in_valid, in_instr, hold,
        input  in_ready, issue_valid, issue_instr, illegal, busy, fifo_count
    );

    modport slave (
        input  in_valid, in_instr, hold,
        output in_ready, issue_valid, issue_instr, illegal, busy, fifo_count
    );

endinterface

// File: rtl/rtype_instr_fifo.sv
// rtl/rtype_instr_fifo.sv - DEPTH x W instruction FIFO with occupancy count, no pass-through
module rtype_instr_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [W-1:0]             i_data,
    input  logic                     i_pop,
    output logic [W-1:0]             o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Storage needs no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule

// File: rtl/rtype_issue_ctrl.sv
// rtl/rtype_issue_ctrl.sv - in-order R-type issue with RAW scoreboard; PERF_CNT_EN adds perf counters
module rtype_issue_ctrl
    import rtype_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int WB_LAT = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    rtype_issue_ctrl_if.slave    bus
`ifdef PERF_CNT_EN
    ,
    output logic [31:0]          perf_issued,
    output logic [31:0]          perf_stall
`endif
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          w_full;
    logic          w_empty;
    logic          w_accept;
    logic          w_legal;
    logic          w_push;
    logic          w_issue;
    logic          w_hazard;
    logic          w_sb_busy;
    logic [31:0]   w_head;
    logic [4:0]    w_rs1;
    logic [4:0]    w_rs2;
    logic [4:0]    w_rd;
    logic [CW-1:0] w_count;

    logic          r_issue_valid;
    logic [31:0]   r_issue_instr;
    logic          r_illegal;
    sb_entry_t     r_sb [WB_LAT];

    assign w_accept = bus.in_valid && !w_full;
    assign w_legal  = is_legal(bus.in_instr);
    assign w_push   = w_accept && w_legal;

    rtype_instr_fifo #(
        .DEPTH (DEPTH),
        .W     (32)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (bus.in_instr),
        .i_pop   (w_issue),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign w_rs1 = rs1(w_head);
    assign w_rs2 = rs2(w_head);
    assign w_rd  = rd(w_head);

    // x0 is never entered in the scoreboard, but reads of x0 are also masked here.
    always_comb begin
        w_hazard  = 1'b0;
        w_sb_busy = 1'b0;
        for (int k = 0; k < WB_LAT; k++) begin
            if (r_sb[k].v) begin
                w_sb_busy = 1'b1;
                if (((w_rs1 != 5'd0) && (r_sb[k].rd == w_rs1)) ||
                    ((w_rs2 != 5'd0) && (r_sb[k].rd == w_rs2))) begin
                    w_hazard = 1'b1;
                end
            end
        end
    end

    assign w_issue = !w_empty && !bus.hold && !w_hazard;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_issue_valid <= 1'b0;
            r_issue_instr <= '0;
            r_illegal     <= 1'b0;
            for (int k = 0; k < WB_LAT; k++) begin
                r_sb[k] <= '0;
            end
        end else begin
            r_issue_valid <= w_issue;
            r_issue_instr <= w_issue ? w_head : 32'd0;
            r_illegal     <= w_accept && !w_legal;
            r_sb[0]       <= '{v: (w_issue && (w_rd != 5'd0)), rd: w_rd};
            for (int k = 1; k < WB_LAT; k++) begin
                r_sb[k] <= r_sb[k-1];
            end
        end
    end

`ifdef PERF_CNT_EN
    logic [31:0] r_perf_issued;
    logic [31:0] r_perf_stall;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_perf_issued <= '0;
            r_perf_stall  <= '0;
        end else begin
            if (w_issue) begin
                r_perf_issued <= r_perf_issued + 32'd1;
            end
            if (!w_empty && !bus.hold && w_hazard) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
        end
    end

    assign perf_issued = r_perf_issued;
    assign perf_stall  = r_perf_stall;
`endif

    assign bus.in_ready    = !w_full;
    assign bus.issue_valid = r_issue_valid;
    assign bus.issue_instr = r_issue_instr;
    assign bus.illegal     = r_illegal;
    assign bus.busy        = !w_empty || w_sb_busy;
    assign bus.fifo_count  = w_count;

endmodule

// File: tb/tb_rtype_issue_ctrl.sv
// tb/tb_rtype_issue_ctrl.sv - scoreboard bench for rtype_issue_ctrl against a ready-time reference model
module tb_rtype_issue_ctrl;

    localparam int DEPTH  = 4;
    localparam int WB_LAT = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    rtype_issue_ctrl_if #(.DEPTH(DEPTH)) bus();

`ifdef PERF_CNT_EN
    logic [31:0] perf_issued;
    logic [31:0] perf_stall;
`endif

    rtype_issue_ctrl #(
        .DEPTH  (DEPTH),
        .WB_LAT (WB_LAT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus)
`ifdef PERF_CNT_EN
        ,
        .perf_issued (perf_issued),
        .perf_stall  (perf_stall)
`endif
    );

    typedef struct {
        logic [31:0] instr;
        int          acc;
    } ent_t;

    ent_t        exp_q[$];
    int          ill_q[$];
    int          reg_ready [32];
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    logic [31:0] m_issued = 0;
    logic [31:0] m_stall = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", nm, cyc, act, exp);
        end
    endtask

    function automatic bit ref_legal(input logic [31:0] w);
        logic [6:0] op;
        logic [6:0] f7;
        logic [2:0] f3;
        op = w[6:0];
        f3 = w[14:12];
        f7 = w[31:25];
        if (op != 7'h33) return 1'b0;
        if (f7 == 7'h00) return 1'b1;
        return (f7 == 7'h20) && (f3 == 3'd0 || f3 == 3'd5);
    endfunction

    function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [4:0] r2,
                                          input logic [4:0] r1, input logic [2:0] f3,
                                          input logic [4:0] rdst);
        return {f7, r2, r1, f3, rdst, 7'h33};
    endfunction

    task automatic model_clear();
        exp_q.delete();
        ill_q.delete();
        foreach (reg_ready[r]) reg_ready[r] = 0;
        m_issued = 0;
        m_stall  = 0;
    endtask

    // Monitor: after each edge, decide from queued entries and register ready times what must have happened.
    logic m_hold;
    logic m_rst;
    int   c;
    bit   have_head, hz, exp_issue, exp_ill;
    ent_t hd;
    int   r1, r2, rdst, cnt;
    bit   sb_busy;

    always @(posedge clk) begin
        m_hold = bus.hold;
        m_rst  = rst;
        cyc++;
        c = cyc;
        #1;
        if (m_rst) begin
            have_head = (exp_q.size() > 0) && (exp_q[0].acc < c);
            hz = 1'b0;
            exp_issue = 1'b0;
            if (have_head) begin
                hd = exp_q[0];
                r1 = int'(hd.instr[19:15]);
                r2 = int'(hd.instr[24:20]);
                rdst = int'(hd.instr[11:7]);
                hz = (r1 != 0 && reg_ready[r1] > c) || (r2 != 0 && reg_ready[r2] > c);
                exp_issue = !m_hold && !hz;
                if (!m_hold && hz) m_stall = m_stall + 1;
            end
            chk("issue_valid", {31'd0, bus.issue_valid}, {31'd0, exp_issue});
            if (exp_issue) begin
                chk("issue_instr", bus.issue_instr, hd.instr);
                void'(exp_q.pop_front());
                if (rdst != 0) reg_ready[rdst] = c + WB_LAT + 1;
                m_issued = m_issued + 1;
            end else begin
                chk("issue_instr_idle", bus.issue_instr, 32'd0);
            end
            exp_ill = (ill_q.size() > 0) && (ill_q[0] == c);
            if (exp_ill) void'(ill_q.pop_front());
            chk("illegal", {31'd0, bus.illegal}, {31'd0, exp_ill});
            cnt = 0;
            foreach (exp_q[i]) if (exp_q[i].acc <= c) cnt++;
            sb_busy = 1'b0;
            for (int r = 1; r < 32; r++) if (reg_ready[r] > c + 1) sb_busy = 1'b1;
            chk("fifo_count", 32'(bus.fifo_count), cnt);
            chk("in_ready", {31'd0, bus.in_ready}, {31'd0, (cnt < DEPTH)});
            chk("busy", {31'd0, bus.busy}, {31'd0, (cnt > 0) || sb_busy});
`ifdef PERF_CNT_EN
            chk("perf_issued", perf_issued, m_issued);
            chk("perf_stall", perf_stall, m_stall);
`endif
        end
    end

    // Stimulus: an accept is known at the negedge, because in_ready only moves on clock edges.
    task automatic drive(input logic v, input logic [31:0] ins, input logic h, output logic acc);
        ent_t e;
        @(negedge clk);
        bus.in_valid = v;
        bus.in_instr = ins;
        bus.hold     = h;
        acc = v && bus.in_ready;
        if (acc) begin
            if (ref_legal(ins)) begin
                e.instr = ins;
                e.acc   = cyc + 1;
                exp_q.push_back(e);
            end else begin
                ill_q.push_back(cyc + 1);
            end
        end
    endtask

    task automatic send(input logic [31:0] ins, input logic h);
        logic acc;
        acc = 1'b0;
        for (int t = 0; t < 40 && !acc; t++) drive(1'b1, ins, h, acc);
        chk("send_accepted", {31'd0, acc}, 32'd1);
    endtask

    task automatic idle(input int n, input logic h);
        logic acc;
        for (int t = 0; t < n; t++) drive(1'b0, 32'd0, h, acc);
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_issue_valid"}, {31'd0, bus.issue_valid}, 32'd0);
        chk({tag, "_issue_instr"}, bus.issue_instr, 32'd0);
        chk({tag, "_illegal"}, {31'd0, bus.illegal}, 32'd0);
        chk({tag, "_fifo_count"}, 32'(bus.fifo_count), 32'd0);
        chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
        chk({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
`ifdef PERF_CNT_EN
        chk({tag, "_perf_issued"}, perf_issued, 32'd0);
        chk({tag, "_perf_stall"}, perf_stall, 32'd0);
`endif
    endtask

    logic [31:0] add_x9, add_x13, sub_x19, add_x0, add_x9_00, bad_f7, ins;
    logic        acc;
    int          sel;

    initial begin
        bus.in_valid = 1'b0;
        bus.in_instr = 32'd0;
        bus.hold     = 1'b0;
        model_clear();
        add_x9    = rtype(7'h00, 5'd4, 5'd7, 3'd0, 5'd9);
        add_x13   = rtype(7'h00, 5'd10, 5'd5, 3'd0, 5'd13);
        sub_x19   = rtype(7'h20, 5'd13, 5'd5, 3'd0, 5'd19);
        add_x0    = rtype(7'h00, 5'd4, 5'd7, 3'd0, 5'd0);
        add_x9_00 = rtype(7'h00, 5'd0, 5'd0, 3'd0, 5'd9);
        bad_f7    = rtype(7'h20, 5'd4, 5'd7, 3'd7, 5'd9);

        repeat (2) @(negedge clk);
        reset_checks("por");
        rst = 1'b1;

        // Independent pair, RAW pair, x0 pair, illegal words.
        send(add_x9, 1'b0);
        send(add_x13, 1'b0);
        idle(4, 1'b0);
        send(add_x13, 1'b0);
        send(sub_x19, 1'b0);
        idle(5, 1'b0);
        send(add_x0, 1'b0);
        send(add_x9_00, 1'b0);
        idle(3, 1'b0);
        send(32'h1234_5678, 1'b0);
        send(bad_f7, 1'b0);
        idle(3, 1'b0);

        // Full FIFO under hold, then release.
        for (int i = 0; i < 4; i++) send(rtype(7'h00, 5'd1, 5'd2, 3'd0, 5'(10 + i)), 1'b1);
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, rtype(7'h00, 5'd1, 5'd2, 3'd0, 5'd14), 1'b1, acc);
            chk("full_no_accept", {31'd0, acc}, 32'd0);
            chk("full_count", 32'(bus.fifo_count), 32'd4);
        end
        send(rtype(7'h00, 5'd1, 5'd2, 3'd0, 5'd14), 1'b0);
        idle(8, 1'b0);

        // Reset with one producer in flight and two queued behind it.
        send(add_x13, 1'b0);
        send(sub_x19, 1'b0);
        send(add_x9, 1'b0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("pre_reset_count", 32'(bus.fifo_count), 32'd2);
        rst = 1'b0;
        model_clear();
        #1;
        reset_checks("mid");
        @(negedge clk);
        rst = 1'b1;
        idle(6, 1'b0);

        // Randomized traffic over a small register set so hazards are frequent.
        for (int t = 0; t < 800; t++) begin
            sel = int'($urandom_range(0, 15));
            if (sel == 0) ins = $urandom;
            else if (sel == 1) ins = rtype(7'h20, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                                           3'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            else if (sel < 4) ins = rtype(7'h20, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                                          (sel == 2) ? 3'd0 : 3'd5, 5'($urandom_range(0, 7)));
            else ins = rtype(7'h00, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                             3'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            drive($urandom_range(0, 3) != 0, ins, $urandom_range(0, 4) == 0, acc);
        end

        for (int t = 0; t < 100 && exp_q.size() > 0; t++) idle(1, 1'b0);
        idle(4, 1'b0);
        chk("drain_empty", exp_q.size(), 32'd0);
        chk("illegal_drained", ill_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
